// File: rtl/dtfm_pkg.sv
// Shared types and helpers for the DTFM frame capture block.
// The optional watchdog is enabled with the DTFM_TIMEOUT_EN macro.
package dtfm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  // Two metastability stages plus one history stage for edge detection
  localparam int SYNC_LEN = 3;

  // Address width for a given depth; never less than 1 bit
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/dtfm_frame_capture_if.sv
// Reader-side bus between the capture block and the frame former.
// The frame former is the master and drives the read strobe and address.
interface dtfm_frame_capture_if #(
  parameter int WORD_W = 12,
  parameter int ADDR_W = 10
);
  logic              iRdEn;
  logic [ADDR_W-1:0] iRdAddr;
  logic [WORD_W-1:0] oRdData;
  logic              oRdBank;
  logic              oFrameRdy;
  logic              oShortFrm;
  logic              oOverrun;
  logic              oTimeout;

  modport master (
    output iRdEn, iRdAddr,
    input  oRdData, oRdBank, oFrameRdy, oShortFrm, oOverrun, oTimeout
  );

  modport slave (
    input  iRdEn, iRdAddr,
    output oRdData, oRdBank, oFrameRdy, oShortFrm, oOverrun, oTimeout
  );
endinterface

// File: rtl/dtfm_pingpong_ram.sv
// Two WORD_W x FRAME_WORDS banks. The writer owns one bank, the reader the
// other; reads have one cycle of latency and the output holds when idle.
module dtfm_pingpong_ram #(
  parameter int WORD_W      = 12,
  parameter int FRAME_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic rd_sel_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [WORD_W-1:0] mem [FRAME_WORDS];
      logic [WORD_W-1:0] q_reg;

      // Write port: only the bank currently owned by the writer
      always_ff @(posedge clk) begin
        if (wr_en && (wr_bank == 1'(gi))) mem[wr_addr] <= wr_data;
      end

      // Registered read port: only the bank currently owned by the reader
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_reg <= '0;
        else if (rd_en && (rd_bank == 1'(gi))) q_reg <= mem[rd_addr];
      end
    end
  endgenerate

  // Remember which bank the last read came from so the output holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_sel_reg <= 1'b0;
    else if (rd_en) rd_sel_reg <= rd_bank;
  end

  assign rd_data = rd_sel_reg ? g_bank[1].q_reg : g_bank[0].q_reg;

endmodule

// File: rtl/dtfm_frame_capture.sv
// DTFM serial capture: synchronises dCLK/dFM/dDAT, deserialises words and
// stores each frame in a ping-pong RAM bank handed to the frame former.
// Optional watchdog abort is built when DTFM_TIMEOUT_EN is defined.
module dtfm_frame_capture
  import dtfm_pkg::*;
#(
  parameter int WORD_W      = 12,
  parameter int FRAME_WORDS = 1024,
  parameter int SAMPLE_RISE = 0,
  parameter int MSB_FIRST   = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic iDCLK,
  input  logic iDFM,
  input  logic iDDAT,
  dtfm_frame_capture_if.slave rd
);

  localparam int ADDR_W = addr_width(FRAME_WORDS);
  localparam int BIT_W  = $clog2(WORD_W + 1);

  // Index 0 = dCLK, 1 = dFM, 2 = dDAT
  logic [2:0] pins;
  logic [2:0] front;
  logic [2:0] rear;
  logic [2:0] level;

  assign pins = {iDDAT, iDFM, iDCLK};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_LEN-1:0] r;

      // Shift the asynchronous pin through the synchroniser chain
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r <= '0;
        else r <= {r[SYNC_LEN-2:0], pins[gi]};
      end

      assign front[gi] = !r[2] &&  r[1];
      assign rear[gi]  =  r[2] && !r[1];
      assign level[gi] =  r[1];
    end
  endgenerate

  logic samp_edge;
  logic dfm_front;
  logic data_bit;

  assign samp_edge = (SAMPLE_RISE != 0) ? front[0] : rear[0];
  assign dfm_front = front[1];
  assign data_bit  = level[2];

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] shift_in;
  logic              wr_en_reg;
  logic              wr_last_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [WORD_W-1:0] wr_data_reg;
  logic              write_bank;
  logic              rd_bank;
  logic              frame_rdy_reg;
  logic              short_frm_reg;
  logic              overrun_reg;
  logic              overrun_seen;
`ifdef DTFM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]   wd_cnt;
  logic              timeout_reg;
`endif

  // Next shift-register value with the current data bit inserted
  always_comb begin
    shift_in = shift_reg;
    if (MSB_FIRST != 0) shift_in = {shift_reg[WORD_W-2:0], data_bit};
    else                shift_in = {data_bit, shift_reg[WORD_W-1:1]};
  end

  // Capture FSM: frame start/restart, bit counting, word writes, bank swap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      addr          <= '0;
      shift_reg     <= '0;
      wr_en_reg     <= 1'b0;
      wr_last_reg   <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      write_bank    <= 1'b0;
      rd_bank       <= 1'b1;
      frame_rdy_reg <= 1'b0;
      short_frm_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      overrun_seen  <= 1'b0;
`ifdef DTFM_TIMEOUT_EN
      wd_cnt        <= '0;
      timeout_reg   <= 1'b0;
`endif
    end else begin
      wr_en_reg     <= 1'b0;
      wr_last_reg   <= 1'b0;
      frame_rdy_reg <= 1'b0;
      short_frm_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef DTFM_TIMEOUT_EN
      timeout_reg   <= 1'b0;
`endif

      // Swap banks in the same cycle the final word lands in RAM
      if (wr_en_reg && wr_last_reg) begin
        write_bank    <= ~write_bank;
        rd_bank       <= write_bank;
        frame_rdy_reg <= 1'b1;
      end

      if (dfm_front) begin
        // Frame marker wins over a coincident sampling edge; that bit is bit 0
        if (state == ST_CAPTURE) short_frm_reg <= 1'b1;
        state        <= ST_CAPTURE;
        addr         <= '0;
        overrun_seen <= 1'b0;
`ifdef DTFM_TIMEOUT_EN
        wd_cnt       <= '0;
`endif
        if (samp_edge) begin
          shift_reg <= shift_in;
          bit_cnt   <= BIT_W'(1);
        end else begin
          bit_cnt   <= '0;
        end
      end else begin
        case (state)
          ST_CAPTURE: begin
            if (samp_edge) begin
              shift_reg <= shift_in;
`ifdef DTFM_TIMEOUT_EN
              wd_cnt    <= '0;
`endif
              if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= addr;
                wr_data_reg <= shift_in;
                bit_cnt     <= '0;
                if (addr == ADDR_W'(FRAME_WORDS - 1)) begin
                  wr_last_reg <= 1'b1;
                  state       <= ST_FULL;
                end else begin
                  addr <= addr + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
`ifdef DTFM_TIMEOUT_EN
            else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
              timeout_reg <= 1'b1;
              state       <= ST_IDLE;
              wd_cnt      <= '0;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
`endif
          end
          ST_FULL: begin
            if (samp_edge && !overrun_seen) begin
              overrun_reg  <= 1'b1;
              overrun_seen <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  dtfm_pingpong_ram #(
    .WORD_W      (WORD_W),
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_reg),
    .wr_bank (write_bank),
    .wr_addr (wr_addr_reg),
    .wr_data (wr_data_reg),
    .rd_en   (rd.iRdEn),
    .rd_bank (rd_bank),
    .rd_addr (rd.iRdAddr),
    .rd_data (rd.oRdData)
  );

  assign rd.oRdBank   = rd_bank;
  assign rd.oFrameRdy = frame_rdy_reg;
  assign rd.oShortFrm = short_frm_reg;
  assign rd.oOverrun  = overrun_reg;
`ifdef DTFM_TIMEOUT_EN
  assign rd.oTimeout  = timeout_reg;
`else
  assign rd.oTimeout  = 1'b0;
`endif

endmodule

// File: tb/tb_dtfm_frame_capture.sv
// Directed bench for dtfm_frame_capture with WORD_W=12, FRAME_WORDS=4,
// falling-edge sampling, MSB first. Watchdog case runs with DTFM_TIMEOUT_EN.
module tb_dtfm_frame_capture;

  localparam int WORD_W = 12;
  localparam int FRAME_WORDS = 4;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic iDCLK;
  logic iDFM;
  logic iDDAT;

  int checks = 0;
  int errors = 0;
  int frm_cnt = 0;
  int short_cnt = 0;
  int ovr_cnt = 0;
  int to_cnt = 0;
  int base_frm;
  int base_short;
  int base_ovr;

  always #5 clk = ~clk;

  dtfm_frame_capture_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) rd_bus ();

  dtfm_frame_capture #(
    .WORD_W      (WORD_W),
    .FRAME_WORDS (FRAME_WORDS),
    .SAMPLE_RISE (0),
    .MSB_FIRST   (1),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .iDCLK (iDCLK),
    .iDFM  (iDFM),
    .iDDAT (iDDAT),
    .rd    (rd_bus)
  );

  // Count output pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (rd_bus.oFrameRdy === 1'b1) frm_cnt = frm_cnt + 1;
    if (rd_bus.oShortFrm === 1'b1) short_cnt = short_cnt + 1;
    if (rd_bus.oOverrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    if (rd_bus.oTimeout === 1'b1) to_cnt = to_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One serial bit: data set with dCLK high, sampled on the following fall
  task automatic send_bit(input logic b);
    @(negedge clk);
    iDDAT = b;
    iDCLK = 1'b1;
    tick(4);
    iDCLK = 1'b0;
    tick(4);
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    for (int i = WORD_W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                            input logic [WORD_W-1:0] w2, input logic [WORD_W-1:0] w3);
    send_word(w0);
    send_word(w1);
    send_word(w2);
    send_word(w3);
  endtask

  task automatic dfm_pulse();
    @(negedge clk);
    iDFM = 1'b1;
    tick(4);
    iDFM = 1'b0;
    tick(4);
  endtask

  task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] exp);
    @(negedge clk);
    rd_bus.iRdEn = 1'b1;
    rd_bus.iRdAddr = a;
    @(negedge clk);
    rd_bus.iRdEn = 1'b0;
    rd_bus.iRdAddr = ~a;
    chk(tag, 32'(rd_bus.oRdData), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic snap();
    base_frm = frm_cnt;
    base_short = short_cnt;
    base_ovr = ovr_cnt;
  endtask

  initial begin
    rst = 1'b0;
    iDCLK = 1'b0;
    iDFM = 1'b0;
    iDDAT = 1'b0;
    rd_bus.iRdEn = 1'b0;
    rd_bus.iRdAddr = '0;
    tick(3);
    chk("reset_rdbank", 32'(rd_bus.oRdBank), 32'd1);
    chk("reset_rddata", 32'(rd_bus.oRdData), 32'h0);
    chk("reset_pulses", 32'({rd_bus.oFrameRdy, rd_bus.oShortFrm, rd_bus.oOverrun, rd_bus.oTimeout}), 32'h0);
    rst = 1'b1;
    tick(2);

    // Full frame into bank 0
    snap();
    dfm_pulse();
    send_frame(12'hA5C, 12'h123, 12'hFFF, 12'h000);
    tick(8);
    chk("full_rdy_cnt", 32'(frm_cnt - base_frm), 32'd1);
    chk("full_rdbank", 32'(rd_bus.oRdBank), 32'd0);
    rd_chk("full_w0", 2'd0, 12'hA5C);
    rd_chk("full_w1", 2'd1, 12'h123);
    rd_chk("full_w2", 2'd2, 12'hFFF);
    rd_chk("full_w3", 2'd3, 12'h000);
    tick(2);
    chk("rd_hold", 32'(rd_bus.oRdData), 32'h000);

    // Short frame from a fresh reset, then a full frame into bank 0
    do_reset();
    snap();
    dfm_pulse();
    for (int i = 0; i < 30; i++) send_bit(i[0]);
    dfm_pulse();
    tick(2);
    chk("short_cnt", 32'(short_cnt - base_short), 32'd1);
    chk("short_no_rdy", 32'(frm_cnt - base_frm), 32'd0);
    chk("short_rdbank", 32'(rd_bus.oRdBank), 32'd1);
    send_frame(12'h111, 12'h222, 12'h333, 12'h444);
    tick(8);
    chk("short_next_rdy", 32'(frm_cnt - base_frm), 32'd1);
    chk("short_next_bank", 32'(rd_bus.oRdBank), 32'd0);
    rd_chk("short_next_w0", 2'd0, 12'h111);
    rd_chk("short_next_w3", 2'd3, 12'h444);

    // Overrun: five extra bits after the full frame
    snap();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    tick(4);
    chk("ovr_cnt", 32'(ovr_cnt - base_ovr), 32'd1);
    chk("ovr_no_rdy", 32'(frm_cnt - base_frm), 32'd0);
    rd_chk("ovr_keep_w1", 2'd1, 12'h222);
    rd_chk("ovr_keep_w2", 2'd2, 12'h333);
    dfm_pulse();
    send_frame(12'h0F0, 12'h765, 12'h89A, 12'hBCD);
    tick(8);
    chk("ovr_next_rdy", 32'(frm_cnt - base_frm), 32'd1);
    chk("ovr_next_bank", 32'(rd_bus.oRdBank), 32'd1);
    rd_chk("ovr_next_w0", 2'd0, 12'h0F0);
    rd_chk("ovr_next_w2", 2'd2, 12'h89A);

    // Coincident dFM front and dCLK fall carrying data 1 (word 0 = 0x9AB)
    snap();
    @(negedge clk);
    iDDAT = 1'b1;
    iDCLK = 1'b1;
    tick(4);
    iDFM = 1'b1;
    iDCLK = 1'b0;
    tick(4);
    iDFM = 1'b0;
    begin
      logic [WORD_W-1:0] w0;
      w0 = 12'h9AB;
      for (int i = WORD_W - 2; i >= 0; i--) send_bit(w0[i]);
    end
    send_word(12'h001);
    send_word(12'h002);
    send_word(12'h003);
    tick(8);
    chk("coin_rdy", 32'(frm_cnt - base_frm), 32'd1);
    chk("coin_bank", 32'(rd_bus.oRdBank), 32'd0);
    rd_chk("coin_w0", 2'd0, 12'h9AB);
    rd_chk("coin_w3", 2'd3, 12'h003);

    // Asynchronous reset at bit 20, then bits with no frame marker
    dfm_pulse();
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_rdbank", 32'(rd_bus.oRdBank), 32'd1);
    chk("arst_rddata", 32'(rd_bus.oRdData), 32'h0);
    chk("arst_pulses", 32'({rd_bus.oFrameRdy, rd_bus.oShortFrm, rd_bus.oOverrun, rd_bus.oTimeout}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    snap();
    send_frame(12'h777, 12'h777, 12'h777, 12'h777);
    tick(8);
    chk("arst_ignored_rdy", 32'(frm_cnt - base_frm), 32'd0);
    chk("arst_ignored_bank", 32'(rd_bus.oRdBank), 32'd1);
    chk("arst_ignored_short", 32'(short_cnt - base_short), 32'd0);
    dfm_pulse();
    send_frame(12'h5A5, 12'h0F0, 12'h3C3, 12'hC3C);
    tick(8);
    chk("arst_next_rdy", 32'(frm_cnt - base_frm), 32'd1);
    chk("arst_next_bank", 32'(rd_bus.oRdBank), 32'd0);
    rd_chk("arst_next_w0", 2'd0, 12'h5A5);
    rd_chk("arst_next_w2", 2'd2, 12'h3C3);

`ifdef DTFM_TIMEOUT_EN
    // Watchdog: 13 bits then dCLK stalls for well over 64 cycles
    snap();
    begin
      int base_to;
      base_to = to_cnt;
      dfm_pulse();
      for (int i = 0; i < 13; i++) send_bit(1'b1);
      tick(100);
      chk("to_cnt", 32'(to_cnt - base_to), 32'd1);
      chk("to_no_rdy", 32'(frm_cnt - base_frm), 32'd0);
      chk("to_bank", 32'(rd_bus.oRdBank), 32'd0);
      // Back in IDLE: further bits alone must not complete a frame
      send_frame(12'h123, 12'h456, 12'h789, 12'hABC);
      tick(8);
      chk("to_idle_rdy", 32'(frm_cnt - base_frm), 32'd0);
    end
`else
    chk("to_tied_zero", 32'(to_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
